// File: rtl/clint_timer.sv
// clint_timer: CLINT window (msip, mtimecmp, mtime) plus external-interrupt conditioning; CLINT_EXT_SYNC_EN adds a 2-flop sync on i_ext_irq.
// Latency: bus ack/err/rdata 1 cycle after request; timer/sw interrupts registered; ext interrupt 1 cycle (2 with CLINT_EXT_SYNC_EN).
// Backpressure: none, one access accepted every cycle, never stalls.
module clint_timer #(
    parameter int TICK_DIV = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_ack,
    output logic              o_err,
    input  logic              i_ext_irq,
    output logic              o_sw_intr,
    output logic              o_timer_intr,
    output logic              o_ext_intr
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        SEL_NONE, SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_MT_LO, SEL_MT_HI
    } sel_t;

    sel_t          sel;
    logic [63:0]   mtime, mtime_nxt;
    logic [63:0]   mtimecmp, mtimecmp_nxt;
    logic          msip, msip_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          tick;
    logic          wr_en;
    logic [31:0]   rdata_nxt;

    // Misaligned offsets never decode, even if the word address would.
    always_comb begin
        sel = SEL_NONE;
        if (i_addr[1:0] == 2'b00) begin
            case (i_addr)
                ADDR_W'(16'h0000): sel = SEL_MSIP;
                ADDR_W'(16'h4000): sel = SEL_CMP_LO;
                ADDR_W'(16'h4004): sel = SEL_CMP_HI;
                ADDR_W'(16'hBFF8): sel = SEL_MT_LO;
                ADDR_W'(16'hBFFC): sel = SEL_MT_HI;
                default:           sel = SEL_NONE;
            endcase
        end
    end

    assign wr_en = i_req && i_we;

    always_comb begin
        rdata_nxt = '0;
        case (sel)
            SEL_MSIP:   rdata_nxt = {31'd0, msip};
            SEL_CMP_LO: rdata_nxt = mtimecmp[31:0];
            SEL_CMP_HI: rdata_nxt = mtimecmp[63:32];
            SEL_MT_LO:  rdata_nxt = mtime[31:0];
            SEL_MT_HI:  rdata_nxt = mtime[63:32];
            default:    rdata_nxt = '0;
        endcase
    end

    // A bus write to either mtime half overrides the tick and restarts the prescaler.
    always_comb begin
        tick         = (presc == PRESC_MAX);
        presc_nxt    = tick ? '0 : presc + PW'(1);
        mtime_nxt    = mtime + 64'(tick);
        mtimecmp_nxt = mtimecmp;
        msip_nxt     = msip;
        if (wr_en) begin
            case (sel)
                SEL_MSIP:   msip_nxt = i_wdata[0];
                SEL_CMP_LO: mtimecmp_nxt = {mtimecmp[63:32], i_wdata};
                SEL_CMP_HI: mtimecmp_nxt = {i_wdata, mtimecmp[31:0]};
                SEL_MT_LO: begin
                    mtime_nxt = {mtime[63:32], i_wdata};
                    presc_nxt = '0;
                end
                SEL_MT_HI: begin
                    mtime_nxt = {i_wdata, mtime[31:0]};
                    presc_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime        <= '0;
            mtimecmp     <= '1;
            msip         <= 1'b0;
            presc        <= '0;
            o_rdata      <= '0;
            o_ack        <= 1'b0;
            o_err        <= 1'b0;
            o_timer_intr <= 1'b0;
        end else begin
            mtime        <= mtime_nxt;
            mtimecmp     <= mtimecmp_nxt;
            msip         <= msip_nxt;
            presc        <= presc_nxt;
            o_ack        <= i_req;
            o_err        <= i_req && (sel == SEL_NONE);
            o_rdata      <= (i_req && !i_we) ? rdata_nxt : 32'd0;
            o_timer_intr <= (mtime_nxt >= mtimecmp_nxt);
        end
    end

    assign o_sw_intr = msip;

`ifdef CLINT_EXT_SYNC_EN
    logic ext_meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_meta   <= 1'b0;
            o_ext_intr <= 1'b0;
        end else begin
            ext_meta   <= i_ext_irq;
            o_ext_intr <= ext_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_ext_intr <= 1'b0;
        end else begin
            o_ext_intr <= i_ext_irq;
        end
    end
`endif

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one DUT with TICK_DIV=1, a second with TICK_DIV=4 for the prescaler.
module tb_clint_timer;
`ifdef CLINT_EXT_SYNC_EN
    localparam int EXT_LAG = 2;
`else
    localparam int EXT_LAG = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, ext_irq;
    logic [15:0] addr;
    logic [31:0] wdata, rdata;
    logic        ack, err, sw_intr, timer_intr, ext_intr;
    logic        req4, we4;
    logic [15:0] addr4;
    logic [31:0] wdata4, rdata4;
    logic        ack4, err4, sw_intr4, timer_intr4, ext_intr4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clint_timer #(.TICK_DIV(1), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_rdata(rdata), .o_ack(ack), .o_err(err), .i_ext_irq(ext_irq),
        .o_sw_intr(sw_intr), .o_timer_intr(timer_intr), .o_ext_intr(ext_intr)
    );

    clint_timer #(.TICK_DIV(4), .ADDR_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_req(req4), .i_we(we4), .i_addr(addr4), .i_wdata(wdata4),
        .o_rdata(rdata4), .o_ack(ack4), .o_err(err4), .i_ext_irq(ext_irq),
        .o_sw_intr(sw_intr4), .o_timer_intr(timer_intr4), .o_ext_intr(ext_intr4)
    );

    // Called at a negedge; returns at the next negedge with that access's response.
    task automatic bus(input bit which, input logic w, input logic [15:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic ak, output logic er);
        if (which) begin
            req4 = 1'b1; we4 = w; addr4 = a; wdata4 = d;
        end else begin
            req = 1'b1; we = w; addr = a; wdata = d;
        end
        @(negedge clk);
        if (which) begin
            rd = rdata4; ak = ack4; er = err4; req4 = 1'b0;
        end else begin
            rd = rdata; ak = ack; er = err; req = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic ak, er;
        rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 16'h4000; wdata = '0; ext_irq = 1'b0;
        req4 = 1'b0; we4 = 1'b0; addr4 = '0; wdata4 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, err, rdata} !== 34'd0) begin
            errors++; $display("FAIL reset_bus ack=%b err=%b rdata=%h exp 0/0/0", ack, err, rdata);
        end
        checks++;
        if ({sw_intr, timer_intr, ext_intr, ack4} !== 4'd0) begin
            errors++; $display("FAIL reset_intr got %b exp 0000", {sw_intr, timer_intr, ext_intr, ack4});
        end
        req = 1'b0;
        rst_n = 1'b1;
        bus(0, 0, 16'h4000, 0, rd, ak, er);
        checks++;
        if ({ak, er, rd} !== {2'b10, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL reset_cmp_lo ack=%b err=%b rdata=%h exp 1/0/ffffffff", ak, er, rd);
        end
        bus(0, 0, 16'h4004, 0, rd, ak, er);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_cmp_hi got %h exp ffffffff", rd);
        end
        bus(0, 0, 16'hBFF8, 0, rd, ak, er);
        checks++;
        if (rd !== 32'd2) begin
            errors++; $display("FAIL reset_mtime_lo got %h exp 2", rd);
        end
        checks++;
        if (timer_intr !== 1'b0) begin
            errors++; $display("FAIL reset_timer_intr got %b exp 0", timer_intr);
        end
    endtask

    task automatic test_prescaler;
        logic [31:0] rd;
        logic ak, er;
        // 3 posedges already elapsed since reset release; 37 more makes 40.
        repeat (37) @(negedge clk);
        bus(1, 0, 16'hBFF8, 0, rd, ak, er);
        checks++;
        if (rd !== 32'd10) begin
            errors++; $display("FAIL presc_40cyc got %0d exp 10", rd);
        end
        bus(1, 1, 16'hBFF8, 32'd100, rd, ak, er);
        repeat (7) @(negedge clk);
        bus(1, 0, 16'hBFF8, 0, rd, ak, er);
        checks++;
        if (rd !== 32'd101) begin
            errors++; $display("FAIL presc_after_write_a got %0d exp 101", rd);
        end
        bus(1, 0, 16'hBFF8, 0, rd, ak, er);
        checks++;
        if (rd !== 32'd102) begin
            errors++; $display("FAIL presc_after_write_b got %0d exp 102", rd);
        end
    endtask

    task automatic test_timer;
        logic [31:0] rd;
        logic ak, er;
        bus(0, 1, 16'hBFF8, 32'd0, rd, ak, er);
        bus(0, 1, 16'h4004, 32'd0, rd, ak, er);
        bus(0, 1, 16'h4000, 32'd20, rd, ak, er);
        checks++;
        if (timer_intr !== 1'b0) begin
            errors++; $display("FAIL timer_armed got %b exp 0", timer_intr);
        end
        repeat (17) @(negedge clk);
        checks++;
        if (timer_intr !== 1'b0) begin
            errors++; $display("FAIL timer_at19 got %b exp 0", timer_intr);
        end
        @(negedge clk);
        checks++;
        if (timer_intr !== 1'b1) begin
            errors++; $display("FAIL timer_at20 got %b exp 1", timer_intr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (timer_intr !== 1'b1) begin
            errors++; $display("FAIL timer_level got %b exp 1", timer_intr);
        end
        bus(0, 1, 16'h4004, 32'd1, rd, ak, er);
        checks++;
        if (timer_intr !== 1'b0) begin
            errors++; $display("FAIL timer_clear got %b exp 0", timer_intr);
        end
    endtask

    task automatic test_carry_wrap;
        logic [31:0] rd;
        logic ak, er;
        bus(0, 1, 16'hBFF8, 32'hFFFF_FFFF, rd, ak, er);
        bus(0, 1, 16'hBFFC, 32'd0, rd, ak, er);
        bus(0, 0, 16'hBFF8, 0, rd, ak, er);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL write_prio_lo got %h exp ffffffff", rd);
        end
        bus(0, 0, 16'hBFFC, 0, rd, ak, er);
        checks++;
        if (rd !== 32'd1) begin
            errors++; $display("FAIL carry_hi got %h exp 1", rd);
        end
        bus(0, 0, 16'hBFF8, 0, rd, ak, er);
        checks++;
        if (rd !== 32'd1) begin
            errors++; $display("FAIL carry_lo got %h exp 1", rd);
        end
        bus(0, 1, 16'hBFFC, 32'hFFFF_FFFF, rd, ak, er);
        bus(0, 1, 16'hBFF8, 32'hFFFF_FFFF, rd, ak, er);
        checks++;
        if (timer_intr !== 1'b1) begin
            errors++; $display("FAIL wrap_pre_intr got %b exp 1", timer_intr);
        end
        bus(0, 0, 16'hBFFC, 0, rd, ak, er);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wrap_pre_hi got %h exp ffffffff", rd);
        end
        checks++;
        if (timer_intr !== 1'b0) begin
            errors++; $display("FAIL wrap_post_intr got %b exp 0", timer_intr);
        end
        bus(0, 0, 16'hBFFC, 0, rd, ak, er);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL wrap_hi got %h exp 0", rd);
        end
        bus(0, 0, 16'hBFF8, 0, rd, ak, er);
        checks++;
        if (rd !== 32'd1) begin
            errors++; $display("FAIL wrap_lo got %h exp 1", rd);
        end
    endtask

    task automatic test_msip;
        logic [31:0] rd;
        logic ak, er;
        checks++;
        if (sw_intr !== 1'b0) begin
            errors++; $display("FAIL msip_init got %b exp 0", sw_intr);
        end
        bus(0, 1, 16'h0000, 32'd1, rd, ak, er);
        checks++;
        if (sw_intr !== 1'b1) begin
            errors++; $display("FAIL msip_set got %b exp 1", sw_intr);
        end
        bus(0, 1, 16'h0000, 32'd0, rd, ak, er);
        checks++;
        if (sw_intr !== 1'b0) begin
            errors++; $display("FAIL msip_clr got %b exp 0", sw_intr);
        end
        bus(0, 1, 16'h0000, 32'hFFFF_FFFF, rd, ak, er);
        bus(0, 0, 16'h0000, 32'hFFFF_FFFF, rd, ak, er);
        checks++;
        if ({sw_intr, rd} !== {1'b1, 32'd1}) begin
            errors++; $display("FAIL msip_read sw=%b rdata=%h exp 1/00000001", sw_intr, rd);
        end
        bus(0, 1, 16'h0000, 32'd0, rd, ak, er);
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic ak, er;
        bus(0, 0, 16'h0002, 0, rd, ak, er);
        checks++;
        if ({ak, er, rd} !== {2'b11, 32'd0}) begin
            errors++; $display("FAIL err_misaligned ack=%b err=%b rdata=%h exp 1/1/0", ak, er, rd);
        end
        bus(0, 0, 16'h1234, 0, rd, ak, er);
        checks++;
        if ({ak, er, rd} !== {2'b11, 32'd0}) begin
            errors++; $display("FAIL err_unmapped ack=%b err=%b rdata=%h exp 1/1/0", ak, er, rd);
        end
        bus(0, 1, 16'h4002, 32'd0, rd, ak, er);
        checks++;
        if ({ak, er} !== 2'b11) begin
            errors++; $display("FAIL err_wr_misaligned ack=%b err=%b exp 1/1", ak, er);
        end
        bus(0, 1, 16'h0001, 32'd1, rd, ak, er);
        checks++;
        if ({er, sw_intr} !== 2'b10) begin
            errors++; $display("FAIL err_msip_unchanged err=%b sw=%b exp 1/0", er, sw_intr);
        end
        bus(0, 0, 16'h4000, 0, rd, ak, er);
        checks++;
        if ({er, rd} !== {1'b0, 32'd20}) begin
            errors++; $display("FAIL err_cmp_unchanged err=%b rdata=%h exp 0/00000014", er, rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic ak, er;
        bus(0, 0, 16'h4000, 0, rd, ak, er);
        checks++;
        if ({ak, rd} !== {1'b1, 32'd20}) begin
            errors++; $display("FAIL b2b_first ack=%b rdata=%h exp 1/00000014", ak, rd);
        end
        bus(0, 0, 16'h4004, 0, rd, ak, er);
        checks++;
        if ({ak, rd} !== {1'b1, 32'd1}) begin
            errors++; $display("FAIL b2b_second ack=%b rdata=%h exp 1/00000001", ak, rd);
        end
        @(negedge clk);
        checks++;
        if ({ack, err, rdata} !== 34'd0) begin
            errors++; $display("FAIL b2b_idle ack=%b err=%b rdata=%h exp 0/0/0", ack, err, rdata);
        end
    endtask

    task automatic test_ext_irq;
        checks++;
        if (ext_intr !== 1'b0) begin
            errors++; $display("FAIL ext_idle got %b exp 0", ext_intr);
        end
        ext_irq = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (ext_intr !== (k >= EXT_LAG)) begin
                errors++; $display("FAIL ext_rise_%0d got %b exp %b", k, ext_intr, (k >= EXT_LAG));
            end
        end
        ext_irq = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (ext_intr !== (k < EXT_LAG)) begin
                errors++; $display("FAIL ext_fall_%0d got %b exp %b", k, ext_intr, (k < EXT_LAG));
            end
        end
    endtask

    task automatic test_reset_inflight;
        logic [31:0] rd;
        logic ak, er;
        bus(0, 1, 16'h0000, 32'd1, rd, ak, er);
        req = 1'b1; we = 1'b1; addr = 16'hBFF8; wdata = 32'd5;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack, err, rdata, sw_intr, timer_intr} !== 36'd0) begin
            errors++; $display("FAIL reset_inflight ack=%b err=%b rdata=%h sw=%b tmr=%b exp all 0",
                               ack, err, rdata, sw_intr, timer_intr);
        end
        req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        bus(0, 0, 16'hBFF8, 0, rd, ak, er);
        checks++;
        if (rd !== 32'd1) begin
            errors++; $display("FAIL reset_mtime_cleared got %h exp 1", rd);
        end
        bus(0, 0, 16'h4000, 0, rd, ak, er);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_cmp_restored got %h exp ffffffff", rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_prescaler;
        test_timer;
        test_carry_wrap;
        test_msip;
        test_errors;
        test_back_to_back;
        test_ext_irq;
        test_reset_inflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
